// File: rtl/rename_resolver_if.sv
// Register query bus between the renamer (master) and the rename resolver (slave).
// Carries the two per-cycle rename queries and their registered answers, the full
// back-pressure flag, in-order commit events and branch resolution (accept/clear).
interface rename_resolver_if #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned RN_WIDTH = 6
);
  // Query, two slots per cycle
  logic [1:0][REG_W-1:0]    q_rs_1;
  logic [1:0][REG_W-1:0]    q_rs_2;
  logic [1:0][REG_W-1:0]    q_rd;
  logic [1:0]               q_rename;
  logic [1:0]               q_tag;
  // Answers, one cycle after the query
  logic [1:0][RN_WIDTH-1:0] r_rn_1;
  logic [1:0][RN_WIDTH-1:0] r_rn_2;
  logic [1:0][RN_WIDTH-1:0] r_rd_rn;
  logic                     full;
  // Commit and branch resolution
  logic                     cm_valid;
  logic [REG_W-1:0]         cm_rd;
  logic [RN_WIDTH-1:0]      cm_rn;
  logic                     tag_accept;
  logic                     tag_clear;

  modport master (
    output q_rs_1, q_rs_2, q_rd, q_rename, q_tag,
    output cm_valid, cm_rd, cm_rn, tag_accept, tag_clear,
    input  r_rn_1, r_rn_2, r_rd_rn, full
  );

  modport slave (
    input  q_rs_1, q_rs_2, q_rd, q_rename, q_tag,
    input  cm_valid, cm_rd, cm_rn, tag_accept, tag_clear,
    output r_rn_1, r_rn_2, r_rd_rn, full
  );
endinterface

// File: rtl/rename_resolver.sv
// Rename resolver: answers two rename queries per cycle with the pending rn of each
// source and a freshly allocated rn for each renaming destination. Keeps a
// speculative map and a shadow map restored on a wrong branch.
// Ports: clk, rst (async active-high), bus (rename_resolver_if.slave).
module rename_resolver #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned RN_WIDTH  = 6,
  parameter int unsigned RN_COUNT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  rename_resolver_if.slave bus
);
  localparam int unsigned MAX_TAG = RN_COUNT - 1;
  localparam int unsigned CNT_W   = RN_WIDTH + 1;

  typedef logic [RN_WIDTH-1:0] rn_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  rn_t                 map_q    [ARCH_REGS];
  rn_t                 map_d    [ARCH_REGS];
  rn_t                 shadow_q [ARCH_REGS];
  rn_t                 shadow_d [ARCH_REGS];
  rn_t                 alloc_ptr_q, alloc_ptr_d;
  cnt_t                in_flight_q, in_flight_d;
  cnt_t                spec_cnt_q, spec_cnt_d;
  logic [1:0][RN_WIDTH-1:0] rn_1_q, rn_1_d;
  logic [1:0][RN_WIDTH-1:0] rn_2_q, rn_2_d;
  logic [1:0][RN_WIDTH-1:0] rd_rn_q, rd_rn_d;

  logic                full_c;
  logic                accept;
  logic [1:0]          alloc;
  logic [1:0][RN_WIDTH-1:0] new_rn;
  rn_t                 ptr_mid, ptr_adv;
  cnt_t                n_alloc, n_spec, in_flight_mid;

  // Next tag in 1..MAX_TAG, skipping 0
  function automatic rn_t tag_inc(input rn_t t);
    return (t == RN_WIDTH'(MAX_TAG)) ? RN_WIDTH'(1) : t + RN_WIDTH'(1);
  endfunction

  // Step the allocation pointer back by n within 1..MAX_TAG
  function automatic rn_t tag_rewind(input rn_t ptr, input cnt_t n);
    cnt_t base;
    base = CNT_W'(ptr) - CNT_W'(1);
    if (base < n) base = base + CNT_W'(MAX_TAG);
    return RN_WIDTH'(base - n + CNT_W'(1));
  endfunction

  // Allocation, lookup and map/shadow/counter update
  always_comb begin
    full_c   = in_flight_q >= CNT_W'(MAX_TAG - 1);
    accept   = !full_c && !bus.tag_clear;
    alloc[0] = accept && bus.q_rename[0] && (bus.q_rd[0] != '0);
    alloc[1] = accept && bus.q_rename[1] && (bus.q_rd[1] != '0);

    ptr_mid   = alloc[0] ? tag_inc(alloc_ptr_q) : alloc_ptr_q;
    ptr_adv   = alloc[1] ? tag_inc(ptr_mid) : ptr_mid;
    new_rn[0] = alloc[0] ? alloc_ptr_q : '0;
    new_rn[1] = alloc[1] ? ptr_mid : '0;

    // map entry 0 is never written non-zero, so rs==0 reads 0 directly
    rn_1_d  = '0;
    rn_2_d  = '0;
    rd_rn_d = '0;
    if (accept) begin
      rn_1_d[0] = map_q[bus.q_rs_1[0]];
      rn_2_d[0] = map_q[bus.q_rs_2[0]];
      rn_1_d[1] = (alloc[0] && bus.q_rs_1[1] == bus.q_rd[0]) ? new_rn[0] : map_q[bus.q_rs_1[1]];
      rn_2_d[1] = (alloc[0] && bus.q_rs_2[1] == bus.q_rd[0]) ? new_rn[0] : map_q[bus.q_rs_2[1]];
      rd_rn_d   = new_rn;
    end

    map_d    = map_q;
    shadow_d = shadow_q;
    // Commit clears only if no younger rename replaced the entry; allocations below override
    if (bus.cm_valid) begin
      if (map_q[bus.cm_rd] == bus.cm_rn)    map_d[bus.cm_rd]    = '0;
      if (shadow_q[bus.cm_rd] == bus.cm_rn) shadow_d[bus.cm_rd] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      if (alloc[k]) begin
        map_d[bus.q_rd[k]] = new_rn[k];
        if (!bus.q_tag[k]) shadow_d[bus.q_rd[k]] = new_rn[k];
      end
    end

    n_alloc       = CNT_W'(alloc[0]) + CNT_W'(alloc[1]);
    n_spec        = CNT_W'(alloc[0] & bus.q_tag[0]) + CNT_W'(alloc[1] & bus.q_tag[1]);
    alloc_ptr_d   = ptr_adv;
    spec_cnt_d    = spec_cnt_q + n_spec;
    in_flight_mid = in_flight_q + n_alloc;

    if (bus.tag_clear) begin
      map_d         = shadow_d;
      alloc_ptr_d   = tag_rewind(alloc_ptr_q, spec_cnt_q);
      in_flight_mid = (in_flight_q > spec_cnt_q) ? in_flight_q - spec_cnt_q : '0;
      spec_cnt_d    = '0;
    end else if (bus.tag_accept) begin
      shadow_d   = map_d;
      spec_cnt_d = '0;
    end

    // A commit with nothing in flight saturates at zero
    in_flight_d = (bus.cm_valid && in_flight_mid != '0) ? in_flight_mid - CNT_W'(1) : in_flight_mid;
  end

  // State and answer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      alloc_ptr_q <= RN_WIDTH'(1);
      in_flight_q <= '0;
      spec_cnt_q  <= '0;
      rn_1_q      <= '0;
      rn_2_q      <= '0;
      rd_rn_q     <= '0;
    end else begin
      map_q       <= map_d;
      shadow_q    <= shadow_d;
      alloc_ptr_q <= alloc_ptr_d;
      in_flight_q <= in_flight_d;
      spec_cnt_q  <= spec_cnt_d;
      rn_1_q      <= rn_1_d;
      rn_2_q      <= rn_2_d;
      rd_rn_q     <= rd_rn_d;
    end
  end

  assign bus.r_rn_1  = rn_1_q;
  assign bus.r_rn_2  = rn_2_q;
  assign bus.r_rd_rn = rd_rn_q;
  assign bus.full    = full_c;
endmodule

// File: tb/tb_rename_resolver.sv
`timescale 1ns/1ps
module tb_rename_resolver;
  localparam int NT = 63;

  typedef struct packed {
    logic [1:0][4:0] rs1, rs2, rd;
    logic [1:0]      ren, tag;
    logic            cmv;
    logic [4:0]      cmrd;
    logic [5:0]      cmrn;
    logic            acc, clr;
  } stim_t;

  typedef struct packed {
    stim_t           s;
    logic [1:0][5:0] rn1, rn2, rdrn;
  } vec_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [5:0] rn;
    logic       spec;
  } rob_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rename_resolver_if #(.REG_W(5), .RN_WIDTH(6)) bus ();
  rename_resolver dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model state
  int m_map [32];
  int m_sh  [32];
  int m_ptr, m_inf, m_spec;
  int e_rn1 [2];
  int e_rn2 [2];
  int e_rd  [2];
  bit e_full;
  rob_t rob [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic stim_t st(input int a0, b0, d0, r0, t0, a1, b1, d1, r1, t1);
    stim_t s;
    s = '0;
    s.rs1[0] = 5'(a0); s.rs2[0] = 5'(b0); s.rd[0] = 5'(d0); s.ren[0] = 1'(r0); s.tag[0] = 1'(t0);
    s.rs1[1] = 5'(a1); s.rs2[1] = 5'(b1); s.rd[1] = 5'(d1); s.ren[1] = 1'(r1); s.tag[1] = 1'(t1);
    return s;
  endfunction

  function automatic vec_t mkv(input int a0, b0, d0, r0, a1, b1, d1, r1, cv, cr, cn,
                               input int x0, y0, z0, x1, y1, z1);
    vec_t v;
    v.s = st(a0, b0, d0, r0, 0, a1, b1, d1, r1, 0);
    v.s.cmv = 1'(cv); v.s.cmrd = 5'(cr); v.s.cmrn = 6'(cn);
    v.rn1[0] = 6'(x0); v.rn2[0] = 6'(y0); v.rdrn[0] = 6'(z0);
    v.rn1[1] = 6'(x1); v.rn2[1] = 6'(y1); v.rdrn[1] = 6'(z1);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_map[i] = 0; m_sh[i] = 0; end
    m_ptr = 1; m_inf = 0; m_spec = 0; e_full = 0;
    for (int k = 0; k < 2; k++) begin e_rn1[k] = 0; e_rn2[k] = 0; e_rd[k] = 0; end
    rob.delete();
  endtask

  // Behavioural view: answers come from the map as it stood before this cycle
  task automatic model_step(input stim_t s);
    int old_map [32];
    bit go;
    bit a [2];
    int nxt;
    old_map = m_map;
    go  = ((NT - m_inf) >= 2) && !s.clr;
    nxt = m_ptr;
    for (int k = 0; k < 2; k++) begin
      e_rn1[k] = 0; e_rn2[k] = 0; e_rd[k] = 0; a[k] = 0;
      if (go) begin
        e_rn1[k] = old_map[s.rs1[k]];
        e_rn2[k] = old_map[s.rs2[k]];
        if (k == 1 && a[0] && s.rs1[1] == s.rd[0]) e_rn1[1] = e_rd[0];
        if (k == 1 && a[0] && s.rs2[1] == s.rd[0]) e_rn2[1] = e_rd[0];
        if (s.ren[k] && s.rd[k] != 0) begin
          a[k] = 1; e_rd[k] = nxt; nxt = nxt % NT + 1;
        end
      end
    end
    if (s.cmv) begin
      if (m_map[s.cmrd] == int'(s.cmrn)) m_map[s.cmrd] = 0;
      if (m_sh[s.cmrd]  == int'(s.cmrn)) m_sh[s.cmrd]  = 0;
    end
    for (int k = 0; k < 2; k++) begin
      if (a[k]) begin
        m_map[s.rd[k]] = e_rd[k];
        if (!s.tag[k]) m_sh[s.rd[k]] = e_rd[k];
        else m_spec++;
        m_inf++;
      end
    end
    m_ptr = nxt;
    if (s.clr) begin
      m_map  = m_sh;
      m_ptr  = ((m_ptr - 1 - m_spec) % NT + NT) % NT + 1;
      m_inf  = m_inf - m_spec;
      m_spec = 0;
    end else if (s.acc) begin
      m_sh   = m_map;
      m_spec = 0;
    end
    if (s.cmv && m_inf > 0) m_inf--;
    e_full = (NT - m_inf) < 2;
  endtask

  task automatic drive(input stim_t s);
    bus.q_rs_1 = s.rs1; bus.q_rs_2 = s.rs2; bus.q_rd = s.rd;
    bus.q_rename = s.ren; bus.q_tag = s.tag;
    bus.cm_valid = s.cmv; bus.cm_rd = s.cmrd; bus.cm_rn = s.cmrn;
    bus.tag_accept = s.acc; bus.tag_clear = s.clr;
  endtask

  task automatic check_out(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s rn1[%0d]", nm, k), int'(bus.r_rn_1[k]), e_rn1[k]);
      chk($sformatf("%s rn2[%0d]", nm, k), int'(bus.r_rn_2[k]), e_rn2[k]);
      chk($sformatf("%s rd_rn[%0d]", nm, k), int'(bus.r_rd_rn[k]), e_rd[k]);
    end
    chk($sformatf("%s full", nm), int'(bus.full), int'(e_full));
  endtask

  task automatic step(input stim_t s, input string nm);
    drive(s);
    model_step(s);
    @(posedge clk);
    #1;
    check_out(nm);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    model_reset();
    @(posedge clk);
    #1;
    check_out("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_run(input int n);
    stim_t s;
    bit    in_spec;
    in_spec = 0;
    for (int i = 0; i < n; i++) begin
      s = st($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), 0,
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), 0);
      if (!in_spec && $urandom_range(0, 7) == 0) in_spec = 1;
      s.tag = in_spec ? 2'b11 : 2'b00;
      if (in_spec && $urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) s.clr = 1'b1;
        else s.acc = 1'b1;
        s.tag   = 2'b00;
        in_spec = 0;
      end
      if (rob.size() > 0 && !rob[0].spec && $urandom_range(0, 2) != 0) begin
        s.cmv = 1'b1; s.cmrd = rob[0].rd; s.cmrn = rob[0].rn;
        void'(rob.pop_front());
      end
      step(s, "rand");
      for (int k = 0; k < 2; k++)
        if (e_rd[k] != 0) rob.push_back('{rd: s.rd[k], rn: 6'(e_rd[k]), spec: s.tag[k]});
      if (s.clr) while (rob.size() > 0 && rob[rob.size() - 1].spec) void'(rob.pop_back());
      if (s.acc) for (int j = 0; j < rob.size(); j++) rob[j].spec = 1'b0;
    end
  endtask

  vec_t  tbl [7];
  stim_t s;

  initial begin
    tbl[0] = mkv(3, 4, 5, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 1,  0, 0, 0);
    tbl[1] = mkv(5, 0, 7, 1,  7, 5, 7, 1,  0, 0, 0,  1, 0, 2,  2, 1, 3);
    tbl[2] = mkv(7, 5, 0, 0,  0, 7, 0, 1,  0, 0, 0,  3, 1, 0,  0, 3, 0);
    tbl[3] = mkv(5, 0, 0, 0,  0, 0, 0, 0,  1, 5, 1,  1, 0, 0,  0, 0, 0);
    tbl[4] = mkv(5, 7, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 3, 0,  0, 0, 0);
    tbl[5] = mkv(7, 0, 0, 0,  0, 0, 0, 0,  1, 7, 2,  3, 0, 0,  0, 0, 0);
    tbl[6] = mkv(7, 5, 7, 1,  7, 0, 0, 1,  0, 0, 0,  3, 0, 4,  4, 0, 0);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].s, $sformatf("vec%0d model", i));
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("vec%0d rn1[%0d]", i, k), int'(bus.r_rn_1[k]), int'(tbl[i].rn1[k]));
        chk($sformatf("vec%0d rn2[%0d]", i, k), int'(bus.r_rn_2[k]), int'(tbl[i].rn2[k]));
        chk($sformatf("vec%0d rd_rn[%0d]", i, k), int'(bus.r_rd_rn[k]), int'(tbl[i].rdrn[k]));
      end
    end

    // Fill to full, query while full, commit releases, then pointer wraps 63 -> 1
    do_reset();
    for (int i = 0; i < 31; i++) step(st(0, 0, 1, 1, 0, 0, 0, 2, 1, 0), "fill");
    chk("full at 62", int'(bus.full), 1);
    step(st(1, 2, 3, 1, 0, 1, 2, 4, 1, 0), "query full");
    chk("full query rd_rn0", int'(bus.r_rd_rn[0]), 0);
    chk("full query rn1", int'(bus.r_rn_1[0]), 0);
    chk("still full", int'(bus.full), 1);
    s = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.cmv = 1'b1; s.cmrd = 5'd1; s.cmrn = 6'd61;
    step(s, "commit full");
    chk("full released", int'(bus.full), 0);
    step(st(1, 2, 3, 1, 0, 0, 0, 4, 1, 0), "wrap");
    chk("wrap rn63", int'(bus.r_rd_rn[0]), 63);
    chk("wrap rn1", int'(bus.r_rd_rn[1]), 1);
    chk("wrap rs2 of x2", int'(bus.r_rn_2[0]), 62);

    // Speculative renames discarded by tag_clear
    do_reset();
    step(st(0, 0, 10, 1, 0, 0, 0, 11, 1, 0), "pre");
    step(st(0, 0, 12, 1, 0, 0, 0, 0, 0, 0), "pre");
    step(st(0, 0, 2, 1, 0, 0, 0, 0, 0, 0), "nonspec");
    chk("nonspec rn4", int'(bus.r_rd_rn[0]), 4);
    step(st(0, 0, 2, 1, 1, 0, 0, 9, 1, 1), "spec");
    chk("spec rn5", int'(bus.r_rd_rn[0]), 5);
    chk("spec rn6", int'(bus.r_rd_rn[1]), 6);
    s = st(2, 9, 3, 1, 0, 0, 0, 0, 0, 0);
    s.clr = 1'b1; s.acc = 1'b1;
    step(s, "clear");
    chk("clear drops query", int'(bus.r_rd_rn[0]), 0);
    step(st(2, 9, 0, 0, 0, 0, 0, 13, 1, 0), "after clear");
    chk("restored map2", int'(bus.r_rn_1[0]), 4);
    chk("restored map9", int'(bus.r_rn_2[0]), 0);
    chk("rewound ptr", int'(bus.r_rd_rn[1]), 5);
    step(st(0, 0, 2, 1, 1, 0, 0, 0, 0, 0), "spec2");
    s = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.acc = 1'b1;
    step(s, "accept");
    s.acc = 1'b0; s.clr = 1'b1;
    step(s, "clear nothing");
    step(st(2, 0, 0, 0, 0, 0, 0, 14, 1, 0), "after accept");
    chk("accepted map2", int'(bus.r_rn_1[0]), 6);
    chk("ptr kept", int'(bus.r_rd_rn[1]), 7);

    // Forwarding from reset, stale commit, async reset mid-burst
    do_reset();
    step(st(0, 0, 7, 1, 0, 7, 0, 7, 1, 0), "fwd");
    chk("fwd rd0", int'(bus.r_rd_rn[0]), 1);
    chk("fwd rn1", int'(bus.r_rn_1[1]), 1);
    chk("fwd rd1", int'(bus.r_rd_rn[1]), 2);
    step(st(7, 0, 5, 1, 0, 0, 0, 5, 1, 0), "map7");
    chk("map7 slot1 wins", int'(bus.r_rn_1[0]), 2);
    step(st(0, 0, 5, 1, 0, 0, 0, 0, 0, 0), "map5");
    s = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.cmv = 1'b1; s.cmrd = 5'd5; s.cmrn = 6'd1;
    step(s, "stale commit");
    step(st(5, 0, 6, 1, 0, 0, 0, 0, 0, 0), "burst");
    chk("stale commit kept", int'(bus.r_rn_1[0]), 5);
    chk("burst rd", int'(bus.r_rd_rn[0]), 6);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst rn1", int'(bus.r_rn_1[0]), 0);
    chk("async rst rd_rn", int'(bus.r_rd_rn[0]), 0);
    chk("async rst full", int'(bus.full), 0);
    model_reset();
    drive('0);
    @(negedge clk);
    rst = 1'b0;

    rand_run(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
